cms_trace_packetizer: RTL and testbench

Parametrised successor to the continuous-monitoring capture path. It samples the executed instruction/PC together with a configurable number of per-event modulo counters and packs each executed instruction into one AXI-Stream beat. Beats are buffered in an internal FIFO, and TLAST is inserted at a programmable interval and at end-of-capture. The block sits between the RISC-V core trace taps and the AXI DMA/FIFO. Software controls it over the address/data control port.

---
 rtl/cms_pkg.sv | 29 ++
 rtl/cms_sync_fifo.sv | 61 ++++++
 rtl/cms_trace_packetizer.sv | 194 +++++++++++++++++++
 tb/tb_cms_trace_packetizer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_pkg.sv
// rtl/cms_pkg.sv - register map, timestamp width and beat layout helpers for the trace packetizer
package cms_pkg;

  localparam int CMS_REG_CTRL  = 'h00;
  localparam int CMS_REG_MASK  = 'h01;
  localparam int CMS_REG_CLEAR = 'h02;

  localparam int CMS_TS_WIDTH  = 64;

  function automatic int cms_pc_offset(input int instr_width);
    return instr_width;
  endfunction

  function automatic int cms_cnt_offset(input int xlen, input int instr_width);
    return instr_width + xlen;
  endfunction

  function automatic int cms_ts_offset(input int xlen, input int instr_width,
                                       input int num_events, input int cnt_width);
    return cms_cnt_offset(xlen, instr_width) + num_events * cnt_width;
  endfunction

  function automatic int cms_payload_width(input int xlen, input int instr_width,
                                           input int num_events, input int cnt_width,
                                           input bit ts_en);
    return cms_ts_offset(xlen, instr_width, num_events, cnt_width) + (ts_en ? CMS_TS_WIDTH : 0);
  endfunction

endpackage

// File: rtl/cms_sync_fifo.sv
// rtl/cms_sync_fifo.sv - fall-through synchronous FIFO with registered storage, full/empty/level
module cms_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cms_sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_level   = r_level;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // Head entry is shown directly; zero while empty so the output is clean out of reset
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array, written on accepted pushes only
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cms_trace_packetizer.sv
// rtl/cms_trace_packetizer.sv - trace beat packetizer top; macro CMS_TIMESTAMP_EN appends a 64-bit capture timestamp
module cms_trace_packetizer
  import cms_pkg::*;
#(
  parameter int XLEN                                = 64,
  parameter int INSTR_WIDTH                         = 32,
  parameter int NUM_EVENTS                          = 37,
  parameter int CNT_WIDTH                           = 7,
  parameter int AXI_DATA_WIDTH                      = 512,
  parameter int FIFO_DEPTH                          = 16,
  parameter int CTRL_ADDR_WIDTH                     = 8,
  parameter int CTRL_DATA_WIDTH                     = 64,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [INSTR_WIDTH-1:0]       instr,
  input  logic [XLEN-1:0]              pc,
  input  logic                         pc_valid,
  input  logic [NUM_EVENTS-1:0]        performance_events,
  input  logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
  input  logic                         ctrl_write_enable,
  input  logic [31:0]                  tlast_interval,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]    M_AXIS_tdata,
  output logic                         M_AXIS_tlast,
  output logic [31:0]                  drop_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef CMS_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int PC_OFF    = cms_pc_offset(INSTR_WIDTH);
  localparam int CNT_OFF   = cms_cnt_offset(XLEN, INSTR_WIDTH);
  localparam int PAYLOAD_W = cms_payload_width(XLEN, INSTR_WIDTH, NUM_EVENTS, CNT_WIDTH, TS_EN);

  generate
    if (PAYLOAD_W > AXI_DATA_WIDTH) begin : g_payload_too_wide
      $error("cms_trace_packetizer: payload does not fit in AXI_DATA_WIDTH");
    end
    if (CTRL_DATA_WIDTH < NUM_EVENTS) begin : g_ctrl_too_narrow
      $error("cms_trace_packetizer: CTRL_DATA_WIDTH must cover NUM_EVENTS");
    end
  endgenerate

  logic                      r_we_q;
  logic                      r_cap_en;
  logic [NUM_EVENTS-1:0]     r_mask;
  logic [CNT_WIDTH-1:0]      r_cnt [NUM_EVENTS];
  logic [31:0]               r_drop;
  logic [31:0]               r_beat_cnt;
  logic                      r_hold;
  logic                      r_hold_tlast;
  logic                      w_wr;
  logic                      w_wr_ctrl;
  logic                      w_wr_mask;
  logic                      w_wr_clear;
  logic                      w_active;
  logic                      w_cap;
  logic                      w_pop;
  logic                      w_accept;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_flush;
  logic                      w_tlast_calc;
  logic [NUM_EVENTS-1:0]     w_inc;
  logic [AXI_DATA_WIDTH-1:0] w_beat;
  logic                      w_unused;

  assign w_unused   = ^ctrl_wdata;
  assign w_wr       = (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) ? (ctrl_write_enable & ~r_we_q)
                                                                 : ctrl_write_enable;
  assign w_wr_ctrl  = w_wr & (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_REG_CTRL));
  assign w_wr_mask  = w_wr & (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_REG_MASK));
  assign w_wr_clear = w_wr & (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_REG_CLEAR));

  assign w_active   = en & r_cap_en;
  assign w_cap      = w_active & pc_valid;
  assign w_pop      = M_AXIS_tvalid & M_AXIS_tready;
  assign w_accept   = w_cap & (~w_full | w_pop);
  assign w_inc      = performance_events & r_mask;

  // Control registers and the write-strobe history used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_q   <= 1'b0;
      r_cap_en <= 1'b0;
      r_mask   <= '1;
    end else begin
      r_we_q <= ctrl_write_enable;
      if (w_wr_ctrl) r_cap_en <= ctrl_wdata[0];
      if (w_wr_mask) r_mask   <= ctrl_wdata[NUM_EVENTS-1:0];
    end
  end

  // Modulo event counters: reload to this cycle's increment on an accepted capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) r_cnt[i] <= '0;
    end else if (w_wr_clear) begin
      for (int i = 0; i < NUM_EVENTS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        r_cnt[i] <= w_accept ? CNT_WIDTH'(w_inc[i]) : r_cnt[i] + CNT_WIDTH'(w_inc[i]);
      end
    end
  end

  // Saturating count of captures lost to a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_wr_clear) begin
      r_drop <= '0;
    end else if (w_cap && !w_accept && !(&r_drop)) begin
      r_drop <= r_drop + 32'd1;
    end
  end

`ifdef CMS_TIMESTAMP_EN
  localparam int TS_OFF = cms_ts_offset(XLEN, INSTR_WIDTH, NUM_EVENTS, CNT_WIDTH);
  logic [CMS_TS_WIDTH-1:0] r_ts;

  // Free-running cycle counter sampled into each beat at capture time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + CMS_TS_WIDTH'(1);
  end
`endif

  // Beat assembly: instr, pc, counters (pre-increment values), optional timestamp, zero fill
  always_comb begin
    w_beat                       = '0;
    w_beat[INSTR_WIDTH-1:0]      = instr;
    w_beat[PC_OFF +: XLEN]       = pc;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      w_beat[CNT_OFF + i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
    end
`ifdef CMS_TIMESTAMP_EN
    w_beat[TS_OFF +: CMS_TS_WIDTH] = r_ts;
`endif
  end

  cms_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_accept),
    .i_data  (w_beat),
    .i_pop   (w_pop),
    .o_data  (M_AXIS_tdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign M_AXIS_tvalid = ~w_empty;
  assign drop_count    = r_drop;

  // Packet framing; a stalled beat keeps the tlast it was first presented with
  assign w_flush      = ~w_active & (fifo_level == LVL_W'(1));
  assign w_tlast_calc = (tlast_interval <= 32'd1) | (r_beat_cnt == tlast_interval - 32'd1) | w_flush;
  assign M_AXIS_tlast = M_AXIS_tvalid & (r_hold ? r_hold_tlast : w_tlast_calc);

  // Remember tlast of a beat waiting on tready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold       <= 1'b0;
      r_hold_tlast <= 1'b0;
    end else begin
      r_hold       <= M_AXIS_tvalid & ~M_AXIS_tready;
      r_hold_tlast <= M_AXIS_tlast;
    end
  end

  // Beats sent in the current packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= M_AXIS_tlast ? 32'd0 : r_beat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cms_trace_packetizer.sv
// tb/tb_cms_trace_packetizer.sv - randomized self-checking bench with a queue-based reference model
module tb_cms_trace_packetizer;

  localparam int NE    = 37;
  localparam int CW    = 7;
  localparam int DW    = 512;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [31:0]     instr;
  logic [63:0]     pc;
  logic            pc_valid;
  logic [NE-1:0]   performance_events;
  logic [7:0]      ctrl_addr;
  logic [63:0]     ctrl_wdata;
  logic            ctrl_write_enable;
  logic [31:0]     tlast_interval;
  logic            M_AXIS_tvalid;
  logic            M_AXIS_tready;
  logic [DW-1:0]   M_AXIS_tdata;
  logic            M_AXIS_tlast;
  logic [31:0]     drop_count;
  logic [4:0]      fifo_level;

  cms_trace_packetizer #(
    .XLEN(64), .INSTR_WIDTH(32), .NUM_EVENTS(NE), .CNT_WIDTH(CW), .AXI_DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH), .CTRL_ADDR_WIDTH(8), .CTRL_DATA_WIDTH(64),
    .CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .performance_events(performance_events), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .tlast_interval(tlast_interval),
    .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_tlast(M_AXIS_tlast), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];
  beat_t         exp_q[$];
  beat_t         got_q[$];
  int            mcnt[NE];
  logic [NE-1:0] mmask;
  bit            mcap;
  logic [31:0]   mdrop;
  int            mbcnt;
  bit            mprev_we;

  bit            m_pop, m_cap, m_tl, m_wr;
  logic [DW-1:0] m_b;
  beat_t         m_e;

  // Reference model and output collector, evaluated mid-cycle on the inputs of that cycle
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < NE; i++) mcnt[i] = 0;
      mmask = '1; mcap = 0; mdrop = 0; mbcnt = 0; mprev_we = 0;
    end else begin
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        m_e.data = M_AXIS_tdata; m_e.last = M_AXIS_tlast;
        got_q.push_back(m_e);
      end
      m_pop = M_AXIS_tready && (mq.size() > 0);
      if (m_pop) begin
        m_tl = (tlast_interval <= 1) || (mbcnt == tlast_interval - 1) ||
               (!(en && mcap) && mq.size() == 1);
        m_e.data = mq.pop_front(); m_e.last = m_tl;
        exp_q.push_back(m_e);
        mbcnt = m_tl ? 0 : mbcnt + 1;
      end
      m_cap = en && mcap && pc_valid;
      if (m_cap && mq.size() < DEPTH) begin
        m_b = '0;
        m_b[31:0]  = instr;
        m_b[95:32] = pc;
        for (int i = 0; i < NE; i++) m_b[96 + CW*i +: CW] = CW'(mcnt[i]);
        mq.push_back(m_b);
        for (int i = 0; i < NE; i++) mcnt[i] = (performance_events[i] && mmask[i]) ? 1 : 0;
      end else begin
        for (int i = 0; i < NE; i++)
          mcnt[i] = (mcnt[i] + ((performance_events[i] && mmask[i]) ? 1 : 0)) % (1 << CW);
        if (m_cap && mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 1;
      end
      m_wr = ctrl_write_enable && !mprev_we;
      mprev_we = ctrl_write_enable;
      if (m_wr) begin
        if (ctrl_addr == 8'h00) mcap = ctrl_wdata[0];
        else if (ctrl_addr == 8'h01) mmask = ctrl_wdata[NE-1:0];
        else if (ctrl_addr == 8'h02) begin
          for (int i = 0; i < NE; i++) mcnt[i] = 0;
          mdrop = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_valid = 0; performance_events = '0; ctrl_write_enable = 0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [63:0] d);
    ctrl_addr = a; ctrl_wdata = d; ctrl_write_enable = 1;
    step();
    ctrl_write_enable = 0;
    step();
  endtask

  task automatic drain(output bit ok);
    idle_inputs();
    M_AXIS_tready = 1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!M_AXIS_tvalid && mq.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[k])
      if (got_q[k].data !== exp_q[k].data || got_q[k].last !== exp_q[k].last) return k;
    return -1;
  endfunction

  function automatic logic [63:0] beat_pc(input int k);
    logic [DW-1:0] d;
    d = got_q[k].data;
    return d[95:32];
  endfunction

  function automatic logic [CW-1:0] beat_cnt0(input int k);
    logic [DW-1:0] d;
    d = got_q[k].data;
    return d[96 +: CW];
  endfunction

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 0; en = 0; instr = '0; pc = '0; idle_inputs();
    ctrl_addr = '0; ctrl_wdata = '0; tlast_interval = 0; M_AXIS_tready = 0;
    #1 rst = 1;
    step(); step();
    rst = 0;
    step();
    checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%0b want=0", M_AXIS_tvalid); end
    checks++; if (M_AXIS_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%0b want=0", M_AXIS_tlast); end
    checks++; if (M_AXIS_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h want=0", M_AXIS_tdata[127:0]); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    en = 1; M_AXIS_tready = 1;
    for (int k = 0; k < 3; k++) begin
      pc_valid = 1; pc = 64'h40 + 64'(k);
      step();
    end
    idle_inputs();
    step();
    checks++; if (got_q.size() != 0 || fifo_level !== 5'd0) begin
      errors++; $display("FAIL reset_capture_disabled got beats=%0d level=%0d want 0/0", got_q.size(), fifo_level);
    end
    clear_queues();
  endtask

  task automatic test_basic();
    bit ok;
    int d;
    wr_reg(8'h00, 64'd1);
    clear_queues();
    M_AXIS_tready = 0;
    pc_valid = 1; pc = 64'h1000; instr = $urandom;
    checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL latency_pre got tvalid=%0b want=0", M_AXIS_tvalid); end
    step();
    pc_valid = 0;
    checks++; if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL latency_n1 got tvalid=%0b want=1", M_AXIS_tvalid); end
    performance_events = NE'(1);
    step(); step();
    performance_events = '0;
    pc_valid = 1; pc = 64'h1004; instr = $urandom;
    step();
    pc = 64'h1008; instr = $urandom;
    step();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_drain_timeout got=timeout want=empty"); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_count got=%0d want=3", got_q.size()); end
    else begin
      checks++; if (beat_pc(0) !== 64'h1000 || beat_pc(1) !== 64'h1004 || beat_pc(2) !== 64'h1008) begin
        errors++; $display("FAIL basic_pcs got=%h/%h/%h want=1000/1004/1008", beat_pc(0), beat_pc(1), beat_pc(2));
      end
      checks++; if (beat_cnt0(1) !== 7'd2) begin errors++; $display("FAIL basic_counter0 got=%0d want=2", beat_cnt0(1)); end
    end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL basic_stream got idx=%0d (n=%0d) want match (n=%0d)", d, got_q.size(), exp_q.size()); end
    clear_queues();
  endtask

  task automatic test_wrap();
    bit ok;
    int d;
    performance_events = NE'(1);
    for (int k = 0; k < 130; k++) step();
    performance_events = '0;
    pc_valid = 1; pc = 64'h2000; instr = $urandom;
    step();
    drain(ok);
    checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL wrap_count got=%0d want=1", got_q.size()); end
    else begin
      checks++; if (beat_cnt0(0) !== 7'd2) begin errors++; $display("FAIL wrap_counter0 got=%0d want=2", beat_cnt0(0)); end
    end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL wrap_stream got idx=%0d want match", d); end
    clear_queues();
  endtask

  task automatic test_full_drop();
    bit ok;
    int d;
    wr_reg(8'h02, 64'd0);
    M_AXIS_tready = 0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      pc_valid = 1; pc = {$urandom, $urandom}; instr = $urandom;
      performance_events = NE'({$urandom, $urandom}) & NE'({$urandom, $urandom});
      step();
    end
    idle_inputs();
    step();
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got=%0d want=16", fifo_level); end
    checks++; if (drop_count !== 32'd3) begin errors++; $display("FAIL full_drop got=%0d want=3", drop_count); end
    drain(ok);
    checks++; if (!ok || got_q.size() != DEPTH) begin errors++; $display("FAIL full_drain got=%0d want=16", got_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL full_stream got idx=%0d want match", d); end
    clear_queues();
  endtask

  task automatic test_tlast();
    bit ok;
    int d;
    int bad;
    tlast_interval = 4;
    M_AXIS_tready = 0;
    for (int k = 0; k < 10; k++) begin
      pc_valid = 1; pc = 64'h3000 + 64'(4*k); instr = $urandom;
      step();
    end
    idle_inputs();
    en = 0;
    step();
    drain(ok);
    bad = 0;
    if (got_q.size() != 10) bad = 99;
    else foreach (got_q[k]) if (got_q[k].last !== ((k == 3) || (k == 7) || (k == 9))) bad++;
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL tlast_pattern got bad=%0d n=%0d want tlast on beats 4,8,10", bad, got_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL tlast_stream got idx=%0d want match", d); end
    en = 1;
    tlast_interval = 0;
    clear_queues();
  endtask

  task automatic test_mask_clear();
    bit ok;
    int d;
    logic [DW-1:0] b;
    wr_reg(8'h01, 64'd0);
    performance_events = '1;
    step(); step(); step();
    performance_events = '1;
    pc_valid = 1; pc = 64'h5000; instr = $urandom;
    step();
    drain(ok);
    checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL mask_count got=%0d want=1", got_q.size()); end
    else begin
      b = got_q[0].data;
      checks++; if (b[96 +: NE*CW] !== '0) begin errors++; $display("FAIL mask_counters got=%h want=0", b[96 +: NE*CW]); end
    end
    checks++; if (drop_count !== 32'd3) begin errors++; $display("FAIL pre_clear_drop got=%0d want=3", drop_count); end
    clear_queues();
    wr_reg(8'h01, '1);
    ctrl_addr = 8'h02; ctrl_write_enable = 1; performance_events = NE'(1);
    step(); step(); step();
    idle_inputs();
    pc_valid = 1; pc = 64'h5004; instr = $urandom;
    step();
    drain(ok);
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL clear_drop got=%0d want=0", drop_count); end
    checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL held_write_count got=%0d want=1", got_q.size()); end
    else begin
      checks++; if (beat_cnt0(0) !== 7'd2) begin errors++; $display("FAIL held_write_once got counter0=%0d want=2", beat_cnt0(0)); end
    end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL mask_stream got idx=%0d want match", d); end
    clear_queues();
  endtask

  task automatic test_random();
    bit ok;
    int d;
    tlast_interval = $urandom_range(0, 5);
    wr_reg(8'h01, {$urandom, $urandom});
    for (int k = 0; k < 400; k++) begin
      pc_valid = ($urandom_range(0, 1) == 1);
      pc = {$urandom, $urandom}; instr = $urandom;
      performance_events = NE'({$urandom, $urandom}) & NE'({$urandom, $urandom});
      M_AXIS_tready = ($urandom_range(0, 9) < 6);
      ctrl_write_enable = ($urandom_range(0, 31) == 0);
      ctrl_addr = 8'($urandom_range(1, 3));
      ctrl_wdata = {$urandom, $urandom};
      step();
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL random_drain got=timeout want=empty"); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL random_stream got idx=%0d n=%0d want match n=%0d", d, got_q.size(), exp_q.size()); end
    checks++; if (drop_count !== mdrop) begin errors++; $display("FAIL random_drop got=%0d want=%0d", drop_count, mdrop); end
    tlast_interval = 0;
    clear_queues();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    M_AXIS_tready = 0;
    for (int k = 0; k < 5; k++) begin
      pc_valid = 1; pc = 64'h6000 + 64'(k); instr = $urandom;
      step();
    end
    idle_inputs();
    checks++; if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got tvalid=%0b want=1", M_AXIS_tvalid); end
    #2 rst = 1;
    #1;
    checks++; if (M_AXIS_tvalid !== 1'b0 || fifo_level !== 5'd0) begin
      errors++; $display("FAIL rst_mid_async got tvalid=%0b level=%0d want 0/0", M_AXIS_tvalid, fifo_level);
    end
    step();
    rst = 0;
    clear_queues();
    M_AXIS_tready = 1;
    for (int k = 0; k < 4; k++) begin
      pc_valid = 1; pc = 64'h7000 + 64'(k);
      step();
    end
    idle_inputs();
    step();
    checks++; if (got_q.size() != 0 || fifo_level !== 5'd0) begin
      errors++; $display("FAIL rst_cap_disabled got beats=%0d level=%0d want 0/0", got_q.size(), fifo_level);
    end
    wr_reg(8'h00, 64'd1);
    M_AXIS_tready = 0;
    pc_valid = 1; pc = 64'h7100; instr = $urandom;
    step();
    idle_inputs();
    checks++; if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL rst_reenable got tvalid=%0b want=1", M_AXIS_tvalid); end
    drain(ok);
    d = first_diff();
    checks++; if (!ok || d != -1 || got_q.size() != 1) begin
      errors++; $display("FAIL rst_reenable_stream got idx=%0d n=%0d want match n=1", d, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_drop();
    test_tlast();
    test_mask_clear();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
